// File: rtl/tdea_cbc_ctrl.sv
// CBC sequencer in front of one TDEA core: three-beat key load, IV/chaining XOR
// around each 64-bit block, one core request in flight, core-wait watchdog.
module tdea_cbc_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:64] K1,
    input  logic [1:64] K2,
    input  logic [1:64] K3,
    input  logic [1:64] IV,
    input  logic        Mode,
    input  logic        Krdy,
    input  logic        IVld,
    input  logic [1:64] Din,
    input  logic        Drdy,
    output logic [1:64] Dout,
    output logic        Dvld,
    output logic        Kvld,
    output logic        BSY,
    output logic        ERR,
    output logic [1:64] c_Din,
    output logic [1:64] c_Kin,
    output logic        c_Drdy,
    output logic        c_Krdy,
    output logic        c_EncDec,
    input  logic [1:64] c_Dout,
    input  logic        c_Dvld,
    input  logic        c_Kvld,
    input  logic        c_BSY
);
    typedef enum logic [3:0] {
        S_IDLE, S_KEY1, S_KEY2, S_KEY3, S_KWAIT, S_READY, S_DSEND, S_DWAIT, S_DOUT
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [1:64] r_k2, r_k3, r_chain, r_dreg;
    logic [7:0]  r_cnt;
    logic        r_cdvld_q;
    logic        w_key_go, w_iv_go, w_data_go, w_kdone, w_dedge, w_tout, w_tick, w_wait_state;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_key_go     = 1'b0;
        w_iv_go      = 1'b0;
        w_data_go    = 1'b0;
        w_kdone      = 1'b0;
        w_dedge      = 1'b0;
        w_tout       = 1'b0;
        w_tick       = (r_cnt == LP_LAST);
        w_wait_state = (r_state == S_KWAIT) || (r_state == S_DWAIT);
        case (r_state)
            S_IDLE: if (Krdy) begin w_key_go = 1'b1; w_next = S_KEY1; end
            S_KEY1: w_next = S_KEY2;
            S_KEY2: w_next = S_KEY3;
            S_KEY3: w_next = S_KWAIT;
            // r_cnt==0 marks the first KWAIT cycle, where the core's Kvld is still stale
            S_KWAIT: begin
                if ((r_cnt != 8'd0) && c_Kvld && !c_BSY) begin
                    w_kdone = 1'b1;
                    w_next  = S_READY;
                end else if (w_tick) begin
                    w_tout = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_READY: begin
                if (Krdy) begin
                    w_key_go = 1'b1;
                    w_next   = S_KEY1;
                end else if (IVld) begin
                    w_iv_go = 1'b1;
                end else if (Drdy) begin
                    w_data_go = 1'b1;
                    w_next    = S_DSEND;
                end
            end
            S_DSEND: w_next = S_DWAIT;
            S_DWAIT: begin
                if (c_Dvld && !r_cdvld_q) begin
                    w_dedge = 1'b1;
                    w_next  = S_DOUT;
                end else if (w_tick) begin
                    w_tout = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DOUT:  w_next = S_READY;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Dout      <= '0;
            Dvld      <= 1'b0;
            Kvld      <= 1'b0;
            BSY       <= 1'b1;
            ERR       <= 1'b0;
            c_Din     <= '0;
            c_Kin     <= '0;
            c_Drdy    <= 1'b0;
            c_Krdy    <= 1'b0;
            c_EncDec  <= 1'b0;
            r_k2      <= '0;
            r_k3      <= '0;
            r_chain   <= '0;
            r_dreg    <= '0;
            r_cnt     <= 8'd0;
            r_cdvld_q <= 1'b0;
        end else begin
            c_Krdy    <= (w_next == S_KEY1) || (w_next == S_KEY2) || (w_next == S_KEY3);
            c_Drdy    <= (w_next == S_DSEND);
            Dvld      <= (w_next == S_DOUT);
            BSY       <= (w_next != S_READY);
            r_cdvld_q <= c_Dvld;
            r_cnt     <= (w_wait_state && (w_next == r_state)) ? r_cnt + 8'd1 : 8'd0;
            if (w_key_go) begin
                r_k2     <= K2;
                r_k3     <= K3;
                r_chain  <= IV;
                c_EncDec <= Mode;
                c_Kin    <= K1;
                Kvld     <= 1'b0;
                ERR      <= 1'b0;
            end
            if (r_state == S_KEY1) c_Kin <= r_k2;
            if (r_state == S_KEY2) c_Kin <= r_k3;
            if (w_iv_go) r_chain <= IV;
            if (w_data_go) begin
                r_dreg <= Din;
                c_Din  <= c_EncDec ? Din : (Din ^ r_chain);
            end
            if (w_kdone) Kvld <= 1'b1;
            if (w_tout) begin
                ERR  <= 1'b1;
                Kvld <= 1'b0;
            end
            // decrypt chains on the ciphertext it was given, encrypt on what it produced
            if (w_dedge) begin
                if (c_EncDec) begin
                    Dout    <= c_Dout ^ r_chain;
                    r_chain <= r_dreg;
                end else begin
                    Dout    <= c_Dout;
                    r_chain <= c_Dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdea_cbc_ctrl.sv
// Bench for tdea_cbc_ctrl: invertible stand-in core, CBC reference model,
// vector table, hand-written corner sequences and randomized traffic.
module tb_tdea_cbc_ctrl;
    localparam int TO = 40;

    logic        CLK = 1'b0;
    logic        RST, Mode, Krdy, IVld, Drdy;
    logic [63:0] K1, K2, K3, IV, Din;
    logic [63:0] Dout, c_Din, c_Kin, c_Dout;
    logic        Dvld, Kvld, BSY, ERR, c_Drdy, c_Krdy, c_EncDec, c_Dvld, c_Kvld, c_BSY;

    always #5 CLK = ~CLK;

    tdea_cbc_ctrl #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .K1(K1), .K2(K2), .K3(K3), .IV(IV), .Mode(Mode),
        .Krdy(Krdy), .IVld(IVld), .Din(Din), .Drdy(Drdy), .Dout(Dout), .Dvld(Dvld),
        .Kvld(Kvld), .BSY(BSY), .ERR(ERR), .c_Din(c_Din), .c_Kin(c_Kin),
        .c_Drdy(c_Drdy), .c_Krdy(c_Krdy), .c_EncDec(c_EncDec), .c_Dout(c_Dout),
        .c_Dvld(c_Dvld), .c_Kvld(c_Kvld), .c_BSY(c_BSY)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // stand-in cipher: keyed, invertible, different for every key slot
    function automatic logic [63:0] enc_f(input logic [63:0] a, b, c, x);
        logic [63:0] t;
        t = x ^ a;
        t = {t[50:0], t[63:51]};
        return (t + b) ^ c;
    endfunction
    function automatic logic [63:0] dec_f(input logic [63:0] a, b, c, y);
        logic [63:0] t;
        t = (y ^ c) - b;
        t = {t[12:0], t[63:13]};
        return t ^ a;
    endfunction

    // ---------------- core model ----------------
    int          core_kl = 1, core_lc = 3;
    bit          core_hang = 0, core_stale = 0, inj_pulse = 0;
    logic [63:0] ck [3];
    logic [63:0] cres;
    int          kb, kcd, dcd;

    always @(posedge CLK) begin
        if (RST) begin
            kb <= 0; kcd <= 0; dcd <= 0;
            c_Dvld <= 1'b0; c_Kvld <= 1'b0; c_BSY <= 1'b0; c_Dout <= '0;
        end else begin
            c_Dvld <= inj_pulse;
            if (c_Krdy) begin
                ck[kb] <= c_Kin;
                kb <= (kb == 2) ? 0 : kb + 1;
                if (!core_stale) begin c_Kvld <= 1'b0; c_BSY <= 1'b1; end
                if (kb == 2) kcd <= core_stale ? 0 : core_kl;
            end else if (kcd != 0) begin
                kcd <= kcd - 1;
                if (kcd == 1) begin c_Kvld <= 1'b1; c_BSY <= 1'b0; end
            end
            if (c_Drdy) begin
                cres  <= c_EncDec ? dec_f(ck[0], ck[1], ck[2], c_Din) : enc_f(ck[0], ck[1], ck[2], c_Din);
                c_BSY <= 1'b1;
                if (!core_hang) dcd <= core_lc;
            end else if (dcd != 0) begin
                dcd <= dcd - 1;
                if (dcd == 1) begin c_Dvld <= 1'b1; c_Dout <= cres; c_BSY <= 1'b0; end
            end
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          n_dvld = 0, n_cdrdy = 0, n_ckrdy = 0, n_dbl = 0;
    int          dvld_cyc, cdrdy_cyc, cdvld_cyc, ckrdy_first, kvld_rise, err_rise;
    logic [63:0] last_dout, last_cdin;
    logic [63:0] kin_b [3];
    logic        p_dvld = 0, p_kvld = 0, p_err = 0, p_cdvld = 0, p_ckrdy = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        p_dvld <= Dvld; p_kvld <= Kvld; p_err <= ERR; p_cdvld <= c_Dvld; p_ckrdy <= c_Krdy;
        if (Dvld) begin n_dvld <= n_dvld + 1; dvld_cyc <= cyc; last_dout <= Dout; end
        if (Dvld && p_dvld) n_dbl <= n_dbl + 1;
        if (c_Drdy) begin n_cdrdy <= n_cdrdy + 1; cdrdy_cyc <= cyc; last_cdin <= c_Din; end
        if (c_Krdy) begin n_ckrdy <= n_ckrdy + 1; kin_b[n_ckrdy % 3] <= c_Kin; end
        if (c_Krdy && !p_ckrdy) ckrdy_first <= cyc;
        if (c_Dvld && !p_cdvld) cdvld_cyc <= cyc;
        if (Kvld && !p_kvld) kvld_rise <= cyc;
        if (ERR && !p_err) err_rise <= cyc;
    end

    // ---------------- CBC reference model ----------------
    logic [63:0] m_k1, m_k2, m_k3, m_chain;
    logic        m_mode;

    task automatic model_key(input logic [63:0] a, b, c, iv, input logic md);
        m_k1 = a; m_k2 = b; m_k3 = c; m_chain = iv; m_mode = md;
    endtask

    task automatic model_block(input logic [63:0] din, output logic [63:0] exp, output logic [63:0] exp_cdin);
        if (!m_mode) begin
            exp_cdin = din ^ m_chain;
            exp      = enc_f(m_k1, m_k2, m_k3, exp_cdin);
            m_chain  = exp;
        end else begin
            exp_cdin = din;
            exp      = dec_f(m_k1, m_k2, m_k3, din) ^ m_chain;
            m_chain  = din;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 300 && BSY; i++) step();
        if (BSY) fail_now("wait_ready");
    endtask

    task automatic load_key(input logic [63:0] a, b, c, iv, input logic md, input int kl, output int t_acc);
        int i;
        if (Kvld) wait_ready();
        core_kl = kl;
        K1 = a; K2 = b; K3 = c; IV = iv; Mode = md; Krdy = 1'b1;
        t_acc = cyc;
        step();
        Krdy = 1'b0;
        for (i = 0; i < 60 && !Kvld; i++) step();
        if (!Kvld) fail_now("kvld_wait");
    endtask

    task automatic ivld_pulse(input logic [63:0] v);
        wait_ready();
        IV = v; IVld = 1'b1;
        step();
        IVld = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] din, input int lc, output logic [63:0] dout, output int t_acc);
        int i, n0;
        wait_ready();
        core_lc = lc;
        n0 = n_dvld;
        Din = din; Drdy = 1'b1;
        t_acc = cyc;
        step();
        Drdy = 1'b0;
        for (i = 0; i < 300 && n_dvld == n0; i++) step();
        if (n_dvld == n0) fail_now("dvld_wait");
        dout = last_dout;
    endtask

    task automatic run_block(input string nm, input logic [63:0] din, input int lc);
        logic [63:0] e, ec, d;
        int t;
        model_block(din, e, ec);
        send_block(din, lc, d, t);
        chk({nm, "_dout"}, d, e);
        chk({nm, "_cdin"}, last_cdin, ec);
        chk({nm, "_lat_cdrdy"}, 64'(cdrdy_cyc), 64'(t + 1));
        chk({nm, "_lat_dvld"}, 64'(dvld_cyc), 64'(cdvld_cyc + 1));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_Dout"}, Dout, 64'h0);
        chk({nm, "_Dvld"}, 64'(Dvld), 64'h0);
        chk({nm, "_Kvld"}, 64'(Kvld), 64'h0);
        chk({nm, "_ERR"}, 64'(ERR), 64'h0);
        chk({nm, "_BSY"}, 64'(BSY), 64'h1);
        chk({nm, "_cDin"}, c_Din, 64'h0);
        chk({nm, "_cKin"}, c_Kin, 64'h0);
        chk({nm, "_cDrdy"}, 64'(c_Drdy), 64'h0);
        chk({nm, "_cKrdy"}, 64'(c_Krdy), 64'h0);
        chk({nm, "_cEncDec"}, 64'(c_EncDec), 64'h0);
    endtask

    // ---------------- vector table ----------------
    localparam logic [1:0] OP_KEY = 2'd0, OP_IV = 2'd1, OP_DATA = 2'd2;
    typedef struct {
        logic [1:0]  op;
        logic        mode;
        logic [63:0] k1, k2, k3, val, exp, exp_cdin;
    } vec_t;
    vec_t tbl [11];

    localparam logic [63:0] KS  = 64'h10316e028c8f3b4a;
    localparam logic [63:0] KA  = 64'h0123456789abcdef;
    localparam logic [63:0] KB  = 64'h23456789abcdef01;
    localparam logic [63:0] KC  = 64'h456789abcdef0123;
    localparam logic [63:0] PT1 = 64'h5468652071756663;
    localparam logic [63:0] PT2 = 64'h6b2062726f776e20;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, e, ec, a, b, c, iv;
        int t, n0, c0, k0, i;

        RST = 1'b1; Mode = 0; Krdy = 0; IVld = 0; Drdy = 0;
        K1 = '0; K2 = '0; K3 = '0; IV = '0; Din = '0;

        tbl[0]  = '{OP_KEY,  1'b0, KS, KS, KS, 64'h0, 64'h0, 64'h0};
        tbl[1]  = '{OP_DATA, 1'b0, 0, 0, 0, 64'h0, 64'h0, 64'h0};
        tbl[2]  = '{OP_KEY,  1'b1, KS, KS, KS, 64'h0, 64'h0, 64'h0};
        tbl[3]  = '{OP_DATA, 1'b0, 0, 0, 0, 64'h0, 64'h0, 64'h0};
        tbl[4]  = '{OP_KEY,  1'b0, KA, KB, KC, 64'h0, 64'h0, 64'h0};
        tbl[5]  = '{OP_DATA, 1'b0, 0, 0, 0, PT1, 64'h0, 64'h0};
        tbl[6]  = '{OP_DATA, 1'b0, 0, 0, 0, PT2, 64'h0, 64'h0};
        tbl[7]  = '{OP_IV,   1'b0, 0, 0, 0, 64'h0, 64'h0, 64'h0};
        tbl[8]  = '{OP_DATA, 1'b0, 0, 0, 0, PT1, 64'h0, 64'h0};
        tbl[9]  = '{OP_KEY,  1'b1, KA, KB, KC, 64'h0, 64'h0, 64'h0};
        tbl[10] = '{OP_DATA, 1'b0, 0, 0, 0, 64'h0, 64'h0, 64'h0};
        for (int j = 0; j < 11; j++) begin
            if (j == 3)  tbl[j].val = tbl[1].exp;
            if (j == 10) tbl[j].val = tbl[5].exp;
            case (tbl[j].op)
                OP_KEY:  model_key(tbl[j].k1, tbl[j].k2, tbl[j].k3, tbl[j].val, tbl[j].mode);
                OP_IV:   m_chain = tbl[j].val;
                default: model_block(tbl[j].val, tbl[j].exp, tbl[j].exp_cdin);
            endcase
        end

        repeat (3) step();
        chk_reset_vals("rst");
        RST = 1'b0;
        step();

        for (int j = 0; j < 11; j++) begin
            case (tbl[j].op)
                OP_KEY:  load_key(tbl[j].k1, tbl[j].k2, tbl[j].k3, tbl[j].val, tbl[j].mode, 1 + int'($urandom % 4), t);
                OP_IV:   ivld_pulse(tbl[j].val);
                default: begin
                    send_block(tbl[j].val, 2 + int'($urandom % 6), d, t);
                    chk($sformatf("tbl%0d_dout", j), d, tbl[j].exp);
                    chk($sformatf("tbl%0d_cdin", j), last_cdin, tbl[j].exp_cdin);
                    chk($sformatf("tbl%0d_kvld", j), 64'(Kvld), 64'h1);
                end
            endcase
        end

        // key-load timing, core reporting a stale Kvld during the first KWAIT cycle
        core_stale = 1;
        k0 = n_ckrdy;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom}; iv = {$urandom, $urandom};
        load_key(a, b, c, iv, 1'b0, 1, t);
        model_key(a, b, c, iv, 1'b0);
        core_stale = 0;
        chk("key_ckrdy_first", 64'(ckrdy_first), 64'(t + 1));
        chk("key_ckrdy_beats", 64'(n_ckrdy - k0), 64'd3);
        chk("key_kin1", kin_b[0], a);
        chk("key_kin2", kin_b[1], b);
        chk("key_kin3", kin_b[2], c);
        chk("key_kvld_rise", 64'(kvld_rise), 64'(t + 6));
        chk("key_encdec", 64'(c_EncDec), 64'h0);
        run_block("lat", {$urandom, $urandom}, 2);

        // Krdy, IVld, Drdy together: key reload wins
        wait_ready();
        c0 = n_cdrdy; k0 = n_ckrdy;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom}; iv = {$urandom, $urandom};
        K1 = a; K2 = b; K3 = c; IV = iv; Mode = 1'b1; Din = {$urandom, $urandom};
        Krdy = 1; IVld = 1; Drdy = 1;
        step();
        Krdy = 0; IVld = 0; Drdy = 0;
        chk("prio_kvld_drop", 64'(Kvld), 64'h0);
        for (i = 0; i < 60 && !Kvld; i++) step();
        chk("prio_kvld_back", 64'(Kvld), 64'h1);
        chk("prio_ckrdy_beats", 64'(n_ckrdy - k0), 64'd3);
        chk("prio_no_cdrdy", 64'(n_cdrdy), 64'(c0));
        model_key(a, b, c, iv, 1'b1);
        run_block("prio", {$urandom, $urandom}, 3);

        // Drdy during DWAIT is dropped
        wait_ready();
        c0 = n_cdrdy; n0 = n_dvld;
        d = {$urandom, $urandom};
        model_block(d, e, ec);
        core_lc = 12; Din = d; Drdy = 1;
        step();
        Drdy = 0;
        repeat (4) step();
        Din = {$urandom, $urandom}; Drdy = 1;
        step();
        Drdy = 0;
        repeat (30) step();
        chk("dwait_cdrdy_once", 64'(n_cdrdy - c0), 64'd1);
        chk("dwait_dvld_once", 64'(n_dvld - n0), 64'd1);
        chk("dwait_dout", last_dout, e);

        // watchdog on a core that never answers
        wait_ready();
        core_hang = 1; n0 = n_dvld;
        Din = {$urandom, $urandom}; Drdy = 1;
        step();
        Drdy = 0;
        for (i = 0; i < TO + 30 && !ERR; i++) step();
        if (!ERR) fail_now("timeout_err");
        chk("timeout_err_cycle", 64'(err_rise), 64'(cdrdy_cyc + 1 + TO));
        chk("timeout_kvld", 64'(Kvld), 64'h0);
        chk("timeout_bsy", 64'(BSY), 64'h1);
        repeat (5) step();
        chk("timeout_no_dvld", 64'(n_dvld), 64'(n0));
        core_hang = 0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom}; iv = {$urandom, $urandom};
        load_key(a, b, c, iv, 1'b0, 2, t);
        model_key(a, b, c, iv, 1'b0);
        chk("timeout_err_clr", 64'(ERR), 64'h0);
        run_block("post_to", {$urandom, $urandom}, 4);

        // reset in the middle of DWAIT, then a late core pulse
        wait_ready();
        n0 = n_dvld;
        core_lc = 20; Din = {$urandom, $urandom}; Drdy = 1;
        step();
        Drdy = 0;
        repeat (6) step();
        RST = 1;
        step();
        RST = 0;
        chk_reset_vals("midrst");
        step();
        inj_pulse = 1;
        step();
        inj_pulse = 0;
        repeat (10) step();
        chk("midrst_no_dvld", 64'(n_dvld), 64'(n0));

        // randomized traffic
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom}; iv = {$urandom, $urandom};
        load_key(a, b, c, iv, 1'($urandom), 1 + int'($urandom % 4), t);
        model_key(a, b, c, iv, Mode);
        for (int j = 0; j < 40; j++) begin
            case ($urandom % 10)
                0: begin
                    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom}; iv = {$urandom, $urandom};
                    load_key(a, b, c, iv, 1'($urandom), 1 + int'($urandom % 4), t);
                    model_key(a, b, c, iv, Mode);
                end
                1: begin
                    iv = {$urandom, $urandom};
                    ivld_pulse(iv);
                    m_chain = iv;
                end
                default: run_block($sformatf("rnd%0d", j), {$urandom, $urandom}, 1 + int'($urandom % 15));
            endcase
        end

        step();
        chk("no_double_dvld", 64'(n_dbl), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
